// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide unit with architectural HI/LO.
//
// Ports:
//   clk      - clock, all state updates on the rising edge
//   rst      - synchronous active-high reset (aborts any operation)
//   i_start  - start an operation (sampled in IDLE only)
//   i_op     - 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   i_op1    - rs operand (multiplicand / dividend)
//   i_op2    - rt operand (multiplier / divisor)
//   i_mthi   - write i_wdata to HI (IDLE/DONE only)
//   i_mtlo   - write i_wdata to LO (IDLE/DONE only)
//   i_wdata  - MTHI/MTLO data
//   o_busy   - high in CALC and FIX
//   o_done   - one-cycle pulse, HI/LO hold the new result
//   o_hi     - HI register
//   o_lo     - LO register
//   o_div0   - divide-by-zero flag with o_done (only with MDU_DIV0_EN)
//
// Optional feature macro: MDU_DIV0_EN. When defined, a divide by zero
// skips the iteration and goes straight to DONE with HI/LO untouched.
// Parameter constraint: 2**CNT_W must equal WIDTH.

module mul_div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic [1:0]       i_op,
   input  logic [WIDTH-1:0] i_op1,
   input  logic [WIDTH-1:0] i_op2,
   input  logic             i_mthi,
   input  logic             i_mtlo,
   input  logic [WIDTH-1:0] i_wdata,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
`ifdef MDU_DIV0_EN
   ,
   output logic             o_div0
`endif
);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               is_div;
   logic               sign_q;    // product / quotient sign
   logic               sign_r;    // remainder sign
   logic [WIDTH-1:0]   opb;       // multiplicand or divisor magnitude
   logic [2*WIDTH-1:0] acc;       // {upper, lower} working register

   // Operand magnitudes for start; only signed ops take absolute values.
   logic               neg1, neg2;
   logic [WIDTH-1:0]   mag1, mag2;

   // Per-iteration next values and sign-corrected results.
   logic [WIDTH:0]     msum;
   logic [WIDTH:0]     part;
   logic [WIDTH+1:0]   diff;
   logic [2*WIDTH-1:0] mul_next;
   logic [2*WIDTH-1:0] div_next;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_raw, rem_raw, quo_fix, rem_fix;

   always_comb begin
      neg1 = i_op[0] & i_op1[WIDTH-1];
      neg2 = i_op[0] & i_op2[WIDTH-1];
      mag1 = neg1 ? -i_op1 : i_op1;
      mag2 = neg2 ? -i_op2 : i_op2;

      // Shift-add: acc = {partial product, remaining multiplier bits}.
      msum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opb : '0)};
      mul_next = {msum, acc[WIDTH-1:1]};

      // Restoring divide: acc = {remainder, remaining dividend/quotient}.
      // The trial value is one bit wider than the remainder so divisors
      // up to 2**WIDTH-1 compare correctly.
      part = acc[2*WIDTH-1:WIDTH-1];
      diff = {1'b0, part} - {2'b00, opb};
      if (diff[WIDTH+1])
         div_next = {part[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
         div_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

      prod_fix = sign_q ? -acc : acc;
      quo_raw  = acc[WIDTH-1:0];
      rem_raw  = acc[2*WIDTH-1:WIDTH];
      quo_fix  = sign_q ? -quo_raw : quo_raw;
      rem_fix  = sign_r ? -rem_raw : rem_raw;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         is_div <= 1'b0;
         sign_q <= 1'b0;
         sign_r <= 1'b0;
         opb    <= '0;
         acc    <= '0;
         o_busy <= 1'b0;
         o_done <= 1'b0;
         o_hi   <= '0;
         o_lo   <= '0;
`ifdef MDU_DIV0_EN
         o_div0 <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (i_start) begin
                  is_div <= i_op[1];
                  sign_q <= i_op[0] & (i_op1[WIDTH-1] ^ i_op2[WIDTH-1]);
                  sign_r <= neg1;
                  opb    <= i_op[1] ? mag2 : mag1;
                  acc    <= {{WIDTH{1'b0}}, (i_op[1] ? mag1 : mag2)};
                  cnt    <= '0;
`ifdef MDU_DIV0_EN
                  if (i_op[1] && i_op2 == '0) begin
                     state  <= DONE;
                     o_done <= 1'b1;
                     o_div0 <= 1'b1;
                  end else begin
                     state  <= CALC;
                     o_busy <= 1'b1;
                  end
`else
                  state  <= CALC;
                  o_busy <= 1'b1;
`endif
               end else begin
                  if (i_mthi) o_hi <= i_wdata;
                  if (i_mtlo) o_lo <= i_wdata;
               end
            end
            CALC: begin
               acc <= is_div ? div_next : mul_next;
               cnt <= cnt + 1'b1;
               if (cnt == '1) state <= FIX;
            end
            FIX: begin
               if (is_div) begin
                  o_hi <= rem_fix;
                  o_lo <= quo_fix;
               end else begin
                  o_hi <= prod_fix[2*WIDTH-1:WIDTH];
                  o_lo <= prod_fix[WIDTH-1:0];
               end
               o_busy <= 1'b0;
               o_done <= 1'b1;
               state  <= DONE;
            end
            DONE: begin
               o_done <= 1'b0;
`ifdef MDU_DIV0_EN
               o_div0 <= 1'b0;
`endif
               if (i_mthi) o_hi <= i_wdata;
               if (i_mtlo) o_lo <= i_wdata;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed, table-driven self-checking bench for
// mul_div_unit, plus hand-written sequences for moves, reset abort and
// the optional divide-by-zero path (MDU_DIV0_EN).

module tb_mul_div_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_start;
   logic [1:0]  i_op;
   logic [31:0] i_op1, i_op2;
   logic        i_mthi, i_mtlo;
   logic [31:0] i_wdata;
   logic        o_busy, o_done;
   logic [31:0] o_hi, o_lo;
`ifdef MDU_DIV0_EN
   logic        o_div0;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   mul_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
      .clk     (clk),
      .rst     (rst),
      .i_start (i_start),
      .i_op    (i_op),
      .i_op1   (i_op1),
      .i_op2   (i_op2),
      .i_mthi  (i_mthi),
      .i_mtlo  (i_mtlo),
      .i_wdata (i_wdata),
      .o_busy  (o_busy),
      .o_done  (o_done),
      .o_hi    (o_hi),
      .o_lo    (o_lo)
`ifdef MDU_DIV0_EN
      ,
      .o_div0  (o_div0)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   localparam logic [1:0] MULTU = 2'b00, MULT = 2'b01, DIVU = 2'b10, DIV = 2'b11;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Starts an operation from idle (called #1 after an edge), then watches
   // 45 cycles. Cycle k is the interval after the k-th edge following the
   // start edge's predecessor, so k=1 is the first cycle after the start edge.
   // poke_kind: 0 none, 1 extra i_start at k=poke_k, 2 i_mtlo at k=poke_k.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int exp_lat, input bit with_mthi,
                         input int poke_k, input int poke_kind,
                         output int first_done, output int ndone,
                         output bit busy_ok, output bit stable_ok, output bit div0_seen);
      logic [31:0] pre_hi, pre_lo;
      pre_hi = o_hi;
      pre_lo = o_lo;
      i_op = op; i_op1 = a; i_op2 = b; i_start = 1'b1;
      if (with_mthi) begin i_mthi = 1'b1; i_wdata = 32'hAAAA5555; end
      @(posedge clk); #1;
      i_start = 1'b0; i_mthi = 1'b0;
      first_done = 0; ndone = 0; busy_ok = 1'b1; stable_ok = 1'b1; div0_seen = 1'b0;
      for (int k = 1; k <= 45; k++) begin
         if (o_done === 1'b1) begin
            ndone++;
            if (first_done == 0) first_done = k;
`ifdef MDU_DIV0_EN
            if (o_div0 === 1'b1) div0_seen = 1'b1;
`endif
         end
         if (o_busy !== ((k < exp_lat) ? 1'b1 : 1'b0)) busy_ok = 1'b0;
         if (k < exp_lat && (o_hi !== pre_hi || o_lo !== pre_lo)) stable_ok = 1'b0;
         if (k == poke_k) begin
            if (poke_kind == 1) i_start = 1'b1;
            if (poke_kind == 2) begin i_mtlo = 1'b1; i_wdata = 32'hDEADBEEF; end
         end
         @(posedge clk); #1;
         i_start = 1'b0; i_mtlo = 1'b0;
      end
   endtask

   vec_t vecs[6];
   int   nvec;
   int   fd, nd;
   bit   bok, sok, d0;
   logic [31:0] hold_hi, hold_lo;

   initial begin
      vecs[0] = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      vecs[1] = '{DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E};
      vecs[2] = '{DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[3] = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      vecs[4] = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      vecs[5] = '{DIVU,  32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF};
`ifdef MDU_DIV0_EN
      nvec = 5;
`else
      nvec = 6;
`endif

      rst = 1'b1; i_start = 1'b0; i_op = '0; i_op1 = '0; i_op2 = '0;
      i_mthi = 1'b0; i_mtlo = 1'b0; i_wdata = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset_hi",   o_hi,   32'h0);
      chk("reset_lo",   o_lo,   32'h0);
      chk("reset_busy", {31'b0, o_busy}, 32'h0);
      chk("reset_done", {31'b0, o_done}, 32'h0);

      for (int i = 0; i < nvec; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, 34, 1'b0, 0, 0, fd, nd, bok, sok, d0);
         chk($sformatf("v%0d_latency", i), fd, 34);
         chk($sformatf("v%0d_ndone", i), nd, 1);
         chk($sformatf("v%0d_busy", i), {31'b0, bok}, 32'h1);
         chk($sformatf("v%0d_stable", i), {31'b0, sok}, 32'h1);
         chk($sformatf("v%0d_hi", i), o_hi, vecs[i].hi);
         chk($sformatf("v%0d_lo", i), o_lo, vecs[i].lo);
`ifdef MDU_DIV0_EN
         chk($sformatf("v%0d_div0", i), {31'b0, d0}, 32'h0);
`endif
      end

      // MULT -3*7 with a second start pulse mid-CALC.
      run_op(MULT, 32'hFFFFFFFD, 32'd7, 34, 1'b0, 5, 1, fd, nd, bok, sok, d0);
      chk("mult_restart_latency", fd, 34);
      chk("mult_restart_ndone", nd, 1);
      chk("mult_restart_busy", {31'b0, bok}, 32'h1);
      chk("mult_hi", o_hi, 32'hFFFFFFFF);
      chk("mult_lo", o_lo, 32'hFFFFFFEB);

      // Simultaneous MTHI/MTLO in IDLE.
      i_mthi = 1'b1; i_mtlo = 1'b1; i_wdata = 32'h12345678;
      @(posedge clk); #1;
      i_mthi = 1'b0; i_mtlo = 1'b0;
      chk("mt_both_hi", o_hi, 32'h12345678);
      chk("mt_both_lo", o_lo, 32'h12345678);

      // MTLO during CALC must not disturb LO.
      run_op(DIVU, 32'd100, 32'd7, 34, 1'b0, 6, 2, fd, nd, bok, sok, d0);
      chk("mtlo_calc_stable", {31'b0, sok}, 32'h1);
      chk("mtlo_calc_lo", o_lo, 32'h0000000E);
      chk("mtlo_calc_hi", o_hi, 32'h00000002);

      // Start together with MTHI: start wins, HI not written.
      i_mthi = 1'b1; i_wdata = 32'h0BADF00D;
      @(posedge clk); #1;
      i_mthi = 1'b0;
      chk("mthi_set", o_hi, 32'h0BADF00D);
      run_op(MULTU, 32'd6, 32'd7, 34, 1'b1, 0, 0, fd, nd, bok, sok, d0);
      chk("start_mthi_stable", {31'b0, sok}, 32'h1);
      chk("start_mthi_latency", fd, 34);
      chk("start_mthi_hi", o_hi, 32'h0);
      chk("start_mthi_lo", o_lo, 32'd42);

`ifdef MDU_DIV0_EN
      // Divide by zero short-circuits to DONE, HI/LO untouched.
      hold_hi = o_hi;
      hold_lo = o_lo;
      run_op(DIVU, 32'd5, 32'd0, 1, 1'b0, 0, 0, fd, nd, bok, sok, d0);
      chk("div0_latency", fd, 1);
      chk("div0_ndone", nd, 1);
      chk("div0_flag", {31'b0, d0}, 32'h1);
      chk("div0_nobusy", {31'b0, bok}, 32'h1);
      chk("div0_hi", o_hi, hold_hi);
      chk("div0_lo", o_lo, hold_lo);
`endif

      // Reset in the middle of a MULTU aborts it.
      i_op = MULTU; i_op1 = 32'd3; i_op2 = 32'd5; i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      repeat (9) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_busy", {31'b0, o_busy}, 32'h0);
      chk("abort_done", {31'b0, o_done}, 32'h0);
      chk("abort_hi", o_hi, 32'h0);
      chk("abort_lo", o_lo, 32'h0);
      nd = 0;
      for (int k = 0; k < 40; k++) begin
         if (o_done === 1'b1 || o_busy === 1'b1) nd++;
         @(posedge clk); #1;
      end
      chk("abort_quiet", nd, 0);
      run_op(MULTU, 32'd3, 32'd5, 34, 1'b0, 0, 0, fd, nd, bok, sok, d0);
      chk("after_abort_latency", fd, 34);
      chk("after_abort_hi", o_hi, 32'h0);
      chk("after_abort_lo", o_lo, 32'd15);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
